// File: rtl/training_data_feeder_if.sv
// Chunk handshake between the training-data feeder (master) and the distance calculator (slave).
// The feeder presents one chunk per ready pulse; the calculator asks for more or signals done.
interface training_data_feeder_if #(
    parameter int unsigned W            = 16,
    parameter int unsigned MAX_ELEMENTS = 4,
    parameter int unsigned TYPE_W       = 2,
    parameter int unsigned SW           = 3
);
    logic                        data_request;
    logic                        calc_done;
    logic [W*MAX_ELEMENTS-1:0]   training_data;
    logic [TYPE_W-1:0]           training_data_type;
    logic                        ready;
    logic [SW-1:0]               sample_index;

    modport master (
        input  data_request,
        input  calc_done,
        output training_data,
        output training_data_type,
        output ready,
        output sample_index
    );

    modport slave (
        output data_request,
        output calc_done,
        input  training_data,
        input  training_data_type,
        input  ready,
        input  sample_index
    );
endinterface

// File: rtl/training_data_feeder.sv
// Stores NUM_SAMPLES training samples and streams each to the calculator in fixed-width chunks,
// filling one element per cycle and pulsing ready when a chunk is complete.
module training_data_feeder #(
    parameter int unsigned M            = 4,
    parameter int unsigned N            = 4,
    parameter int unsigned W            = 16,
    parameter int unsigned MAX_ELEMENTS = 4,
    parameter int unsigned TYPE_W       = 2,
    parameter int unsigned NUM_SAMPLES  = 8,
    localparam int unsigned DEPTH       = NUM_SAMPLES * M * N,
    localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned SW          = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [W-1:0]         wr_data,
    input  logic                 type_wr_en,
    input  logic [SW-1:0]        type_wr_addr,
    input  logic [TYPE_W-1:0]    type_wr_data,
    input  logic                 start,
    training_data_feeder_if.master bus,
    output logic                 busy,
    output logic                 all_done,
    output logic                 protocol_err
);

    localparam int unsigned ELEMS  = M * N;
    localparam int unsigned CHUNKS = (ELEMS + MAX_ELEMENTS - 1) / MAX_ELEMENTS;
    localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int unsigned FW     = (MAX_ELEMENTS > 1) ? $clog2(MAX_ELEMENTS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StPresent,
        StWait,
        StFinished
    } state_e;

    state_e                      state_q, state_d;
    logic [CW-1:0]               chunk_q, chunk_d;
    logic [FW-1:0]               fill_q, fill_d;
    logic [SW-1:0]               sample_q, sample_d;
    logic [W*MAX_ELEMENTS-1:0]   data_q, data_d;
    logic [TYPE_W-1:0]           type_q, type_d;
    logic                        busy_q, busy_d;
    logic                        all_done_q, all_done_d;
    logic                        err_q, err_d;

    logic [W-1:0]                mem [DEPTH];
    logic [TYPE_W-1:0]           type_mem [NUM_SAMPLES];

    logic                        wr_ok;
    logic [31:0]                 elem_idx;
    logic [AW-1:0]               rd_addr;
    logic [W-1:0]                elem_val;

    // Storage is only writable while no stream is in flight.
    assign wr_ok = (state_q == StIdle) || (state_q == StFinished);

    always_ff @(posedge clk) begin
        if (wr_ok && wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
        if (wr_ok && type_wr_en && (32'(type_wr_addr) < NUM_SAMPLES)) begin
            type_mem[type_wr_addr] <= type_wr_data;
        end
    end

    // Element past the end of the sample reads as zero padding.
    always_comb begin
        elem_idx = 32'(chunk_q) * MAX_ELEMENTS + 32'(fill_q);
        rd_addr  = AW'(32'(sample_q) * ELEMS + elem_idx);
        elem_val = '0;
        if (elem_idx < ELEMS) begin
            elem_val = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            chunk_q    <= '0;
            fill_q     <= '0;
            sample_q   <= '0;
            data_q     <= '0;
            type_q     <= '0;
            busy_q     <= 1'b0;
            all_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            chunk_q    <= chunk_d;
            fill_q     <= fill_d;
            sample_q   <= sample_d;
            data_q     <= data_d;
            type_q     <= type_d;
            busy_q     <= busy_d;
            all_done_q <= all_done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        chunk_d    = chunk_q;
        fill_d     = fill_q;
        sample_d   = sample_q;
        data_d     = data_q;
        type_d     = type_q;
        busy_d     = busy_q;
        all_done_d = all_done_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle, StFinished: begin
                if (start) begin
                    chunk_d    = '0;
                    sample_d   = '0;
                    fill_d     = '0;
                    busy_d     = 1'b1;
                    all_done_d = 1'b0;
                    err_d      = 1'b0;
                    state_d    = StFill;
                end
            end
            StFill: begin
                for (int i = 0; i < MAX_ELEMENTS; i++) begin
                    if (fill_q == FW'(i)) begin
                        data_d[i*W +: W] = elem_val;
                    end
                end
                if ((chunk_q == '0) && (fill_q == '0)) begin
                    type_d = type_mem[sample_q];
                end
                if (fill_q == FW'(MAX_ELEMENTS - 1)) begin
                    fill_d  = '0;
                    state_d = StPresent;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
            StPresent: begin
                state_d = StWait;
            end
            StWait: begin
                // calc_done takes priority; a simultaneous request is silently dropped.
                if (bus.calc_done) begin
                    if (sample_q == SW'(NUM_SAMPLES - 1)) begin
                        busy_d     = 1'b0;
                        all_done_d = 1'b1;
                        state_d    = StFinished;
                    end else begin
                        sample_d = sample_q + 1'b1;
                        chunk_d  = '0;
                        fill_d   = '0;
                        state_d  = StFill;
                    end
                end else if (bus.data_request) begin
                    if (chunk_q == CW'(CHUNKS - 1)) begin
                        err_d = 1'b1;
                    end else begin
                        chunk_d = chunk_q + 1'b1;
                        fill_d  = '0;
                        state_d = StFill;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.training_data      = data_q;
    assign bus.training_data_type = type_q;
    assign bus.ready              = (state_q == StPresent);
    assign bus.sample_index       = sample_q;
    assign busy                   = busy_q;
    assign all_done               = all_done_q;
    assign protocol_err           = err_q;

endmodule

// File: tb/tb_training_data_feeder.sv
// Directed bench for training_data_feeder: M=N=2, three-element chunks, two stored samples.
module tb_training_data_feeder;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [15:0]   wr_data;
    logic          type_wr_en;
    logic [0:0]    type_wr_addr;
    logic [1:0]    type_wr_data;
    logic          start;
    logic          busy;
    logic          all_done;
    logic          protocol_err;

    int checks;
    int errors;
    int lat;

    training_data_feeder_if #(.W(16), .MAX_ELEMENTS(3), .TYPE_W(2), .SW(1)) bus ();

    training_data_feeder #(
        .M(2), .N(2), .W(16), .MAX_ELEMENTS(3), .TYPE_W(2), .NUM_SAMPLES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .type_wr_en   (type_wr_en),
        .type_wr_addr (type_wr_addr),
        .type_wr_data (type_wr_data),
        .start        (start),
        .bus          (bus),
        .busy         (busy),
        .all_done     (all_done),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one-cycle pulses at a negedge, then count negedges until ready (or -1 on budget).
    task automatic pulse_wait(input logic s, input logic r, input logic d, input int budget,
                              output int l);
        start = s;
        bus.data_request = r;
        bus.calc_done = d;
        l = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            start = 1'b0;
            bus.data_request = 1'b0;
            bus.calc_done = 1'b0;
            wr_en = 1'b0;
            if (bus.ready) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic expect_chunk(input string tag, input int l, input logic [47:0] data,
                                input logic [1:0] typ, input logic idx);
        check({tag, "_latency"}, 64'(l), 64'(4));
        check({tag, "_data"}, 64'(bus.training_data), 64'(data));
        check({tag, "_type"}, 64'(bus.training_data_type), 64'(typ));
        check({tag, "_index"}, 64'(bus.sample_index), 64'(idx));
        check({tag, "_busy"}, 64'(busy), 64'(1));
        @(negedge clk);
        check({tag, "_ready_one_cycle"}, 64'(bus.ready), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, 64'(bus.training_data), 64'(0));
        check({tag, "_type"}, 64'(bus.training_data_type), 64'(0));
        check({tag, "_ready"}, 64'(bus.ready), 64'(0));
        check({tag, "_index"}, 64'(bus.sample_index), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_all_done"}, 64'(all_done), 64'(0));
        check({tag, "_err"}, 64'(protocol_err), 64'(0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        type_wr_en = 1'b0;
        type_wr_addr = '0;
        type_wr_data = '0;
        start = 1'b0;
        bus.data_request = 1'b0;
        bus.calc_done = 1'b0;

        #3;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Sample 0 = 1..4 (type 1), sample 1 = 5..8 (type 2).
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_addr = 3'(i);
            wr_data = 16'(i + 1);
            @(negedge clk);
        end
        wr_en = 1'b0;
        type_wr_en = 1'b1;
        type_wr_addr = 1'b0;
        type_wr_data = 2'd1;
        @(negedge clk);
        type_wr_addr = 1'b1;
        type_wr_data = 2'd2;
        @(negedge clk);
        type_wr_en = 1'b0;

        // Run A: full walk through both samples, including an over-request.
        pulse_wait(1'b1, 1'b0, 1'b0, 12, lat);
        expect_chunk("s1_first", lat, {16'd3, 16'd2, 16'd1}, 2'd1, 1'b0);

        wr_en = 1'b1;
        wr_addr = 3'd0;
        wr_data = 16'd99;
        pulse_wait(1'b1, 1'b0, 1'b0, 6, lat);
        check("busy_start_no_ready", 64'(lat), 64'(-1));
        check("busy_start_index", 64'(bus.sample_index), 64'(0));
        check("busy_start_data_held", 64'(bus.training_data), 64'({16'd3, 16'd2, 16'd1}));

        pulse_wait(1'b0, 1'b1, 1'b0, 12, lat);
        expect_chunk("s2_chunk1", lat, {16'd0, 16'd0, 16'd4}, 2'd1, 1'b0);
        check("s2_err_before", 64'(protocol_err), 64'(0));

        pulse_wait(1'b0, 1'b1, 1'b0, 6, lat);
        check("s2_over_request_no_ready", 64'(lat), 64'(-1));
        check("s2_protocol_err", 64'(protocol_err), 64'(1));

        pulse_wait(1'b0, 1'b0, 1'b1, 12, lat);
        expect_chunk("a_sample1", lat, {16'd7, 16'd6, 16'd5}, 2'd2, 1'b1);
        pulse_wait(1'b0, 1'b1, 1'b0, 12, lat);
        expect_chunk("a_sample1_chunk1", lat, {16'd0, 16'd0, 16'd8}, 2'd2, 1'b1);

        pulse_wait(1'b0, 1'b0, 1'b1, 6, lat);
        check("s4_no_ready", 64'(lat), 64'(-1));
        check("s4_all_done", 64'(all_done), 64'(1));
        check("s4_busy", 64'(busy), 64'(0));

        // Run B: restart; the write during WAIT must not have landed.
        pulse_wait(1'b1, 1'b0, 1'b0, 12, lat);
        expect_chunk("s4_restart", lat, {16'd3, 16'd2, 16'd1}, 2'd1, 1'b0);
        check("s4_restart_all_done", 64'(all_done), 64'(0));
        check("s4_restart_err_cleared", 64'(protocol_err), 64'(0));

        pulse_wait(1'b0, 1'b1, 1'b1, 12, lat);
        expect_chunk("s3_done_wins", lat, {16'd7, 16'd6, 16'd5}, 2'd2, 1'b1);
        check("s3_no_err", 64'(protocol_err), 64'(0));
        pulse_wait(1'b0, 1'b1, 1'b0, 12, lat);
        expect_chunk("s3_chunk1", lat, {16'd0, 16'd0, 16'd8}, 2'd2, 1'b1);
        pulse_wait(1'b0, 1'b0, 1'b1, 6, lat);
        check("b_all_done", 64'(all_done), 64'(1));

        // Scenario 6: async reset while filling sample 1.
        pulse_wait(1'b1, 1'b0, 1'b0, 12, lat);
        expect_chunk("s6_pre", lat, {16'd3, 16'd2, 16'd1}, 2'd1, 1'b0);
        bus.calc_done = 1'b1;
        @(negedge clk);
        bus.calc_done = 1'b0;
        @(negedge clk);
        check("s6_mid_fill_index", 64'(bus.sample_index), 64'(1));
        check("s6_mid_fill_type", 64'(bus.training_data_type), 64'(2));
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("s6_async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_wait(1'b1, 1'b0, 1'b0, 12, lat);
        expect_chunk("s6_after_reset", lat, {16'd3, 16'd2, 16'd1}, 2'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
